// File: rtl/led_pkg.sv
// Constants and types shared by the LED stream encoder and decoder.
// Timing constants assume a 50 MHz system clock.
package led_pkg;

    localparam int CLK_PERIOD_NS     = 20;
    localparam int BIT_PERIOD_CYCLES = 61;
    localparam int T0H_CYCLES        = 20;
    localparam int T1H_CYCLES        = 40;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_stream_decoder_if.sv
// Serial line in, decoded pixel stream out, plus the decoder FSM state for debug.
interface led_stream_decoder_if #(
    parameter int IDX_W = 8
);
    import led_pkg::*;

    // Handshake: pixel_valid and frame_done are single-cycle strobes with no
    // ready/backpressure; pixel_data and pixel_index are valid only while
    // pixel_valid is high and the sink must accept them in that cycle.
    logic             din;
    pixel_t           pixel_data;
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic             frame_done;
    logic             bit_error;
    led_state_e       state;

    modport master (
        input  din,
        output pixel_data, pixel_valid, pixel_index, frame_done, bit_error, state
    );

    modport slave (
        output din,
        input  pixel_data, pixel_valid, pixel_index, frame_done, bit_error, state
    );

endinterface

// File: rtl/led_stream_decoder_pulse_width_meter.sv
// Synchronizes the serial line, detects edges and measures the length of the
// current or most recent high and low runs with saturating counters.
module pulse_width_meter #(
    parameter int MAX_HIGH  = 55,
    parameter int RESET_LOW = 2500,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] low_cnt_o
);

    localparam logic [CNT_W-1:0] HIGH_SAT = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0] LOW_SAT  = CNT_W'(RESET_LOW);

    logic             sync1_q, din_s_q, din_prev_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

    // Each counter restarts at 1 on its opening edge and holds its final
    // length while the line is in the opposite level, so it is still readable
    // when the registered closing edge reaches the FSM.
    always_comb begin
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        if (din_s_q) begin
            if (!din_prev_q)             high_cnt_d = CNT_W'(1);
            else if (high_cnt_q != HIGH_SAT) high_cnt_d = high_cnt_q + 1'b1;
        end else begin
            if (din_prev_q)              low_cnt_d = CNT_W'(1);
            else if (low_cnt_q != LOW_SAT)   low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sampled-high reset state: a line already high is not a rising edge.
            sync1_q    <= 1'b1;
            din_s_q    <= 1'b1;
            din_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            sync1_q    <= din_i;
            din_s_q    <= sync1_q;
            din_prev_q <= din_s_q;
            rise_q     <= din_s_q & ~din_prev_q;
            fall_q     <= ~din_s_q & din_prev_q;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
        end
    end

    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign high_cnt_o = high_cnt_q;
    assign low_cnt_o  = low_cnt_q;

endmodule

// File: rtl/led_stream_decoder.sv
// Single-wire LED data receiver: classifies high pulses into bits, assembles
// 24-bit GRB pixels MSB first and flags the latch gap that ends a frame.
module led_stream_decoder
    import led_pkg::*;
#(
    parameter int BIT_THRESH = 30,
    parameter int MIN_HIGH   = 5,
    parameter int MAX_HIGH   = 55,
    parameter int RESET_LOW  = 2500,
    parameter int IDX_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    led_stream_decoder_if.master bus
);

    localparam int               CNT_W   = $clog2(RESET_LOW + 1);
    localparam logic [CNT_W-1:0] LOW_SAT = CNT_W'(RESET_LOW);

    logic             rise, fall;
    logic [CNT_W-1:0] high_cnt, low_cnt;

    pulse_width_meter #(
        .MAX_HIGH (MAX_HIGH),
        .RESET_LOW(RESET_LOW),
        .CNT_W    (CNT_W)
    ) u_meter (
        .clk       (clk),
        .reset     (reset),
        .din_i     (bus.din),
        .rise_o    (rise),
        .fall_o    (fall),
        .high_cnt_o(high_cnt),
        .low_cnt_o (low_cnt)
    );

    led_state_e       state_q;
    logic [23:0]      shreg_q;
    logic [4:0]       bit_cnt_q;
    pixel_t           pixel_data_q;
    logic             pixel_valid_q;
    logic [IDX_W-1:0] pixel_index_q;
    logic             frame_done_q;
    logic             bit_error_q;
    logic             partial_q;

    logic bit_val, width_bad;
    assign bit_val   = (high_cnt >= CNT_W'(BIT_THRESH));
    assign width_bad = (high_cnt < CNT_W'(MIN_HIGH)) || (high_cnt > CNT_W'(MAX_HIGH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            frame_done_q  <= 1'b0;
            bit_error_q   <= 1'b0;
            partial_q     <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (pixel_valid_q) pixel_index_q <= pixel_index_q + 1'b1;
            // A partial-pixel error raised with frame_done carries into the next frame.
            if (frame_done_q && !partial_q) bit_error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rise) state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        shreg_q <= {shreg_q[22:0], bit_val};
                        if (width_bad) bit_error_q <= 1'b1;
                        if (bit_cnt_q == 5'd23) begin
                            pixel_valid_q <= 1'b1;
                            pixel_data_q  <= {shreg_q[22:0], bit_val};
                            bit_cnt_q     <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_q <= ST_HIGH;
                    end else if (low_cnt == LOW_SAT) begin
                        frame_done_q  <= 1'b1;
                        bit_cnt_q     <= '0;
                        pixel_index_q <= '0;
                        partial_q     <= (bit_cnt_q != 5'd0);
                        if (bit_cnt_q != 5'd0) bit_error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pixel_data  = pixel_data_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_index = pixel_index_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.bit_error   = bit_error_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Directed bench for led_stream_decoder: drives encoded pulse trains on din and
// checks decoded pixels, strobe timing, frame gaps and error flags.
module tb_led_stream_decoder;
    import led_pkg::*;

    localparam int RESET_LOW = 2500;
    localparam int IDX_W     = 8;
    // din fall -> 2 synchronizer cycles -> synced fall, then RESET_LOW + 1.
    localparam int FD_LAT    = 2 + RESET_LOW + 1;
    localparam int PV_LAT    = 4;

    logic clk = 1'b0;
    logic reset;
    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    led_stream_decoder_if #(.IDX_W(IDX_W)) bus();

    led_stream_decoder #(
        .BIT_THRESH(30),
        .MIN_HIGH  (5),
        .MAX_HIGH  (55),
        .RESET_LOW (RESET_LOW),
        .IDX_W     (IDX_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0]      exp_q[$];
    logic [23:0]      got_q[$];
    logic [IDX_W-1:0] got_idx_q[$];
    int unsigned      pv_cyc, fd_cyc, fall_cyc;
    int               fd_cnt = 0;

    always @(negedge clk) begin
        if (bus.pixel_valid) begin
            got_q.push_back(bus.pixel_data);
            got_idx_q.push_back(bus.pixel_index);
            pv_cyc = cyc;
        end
        if (bus.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #(CLK_PERIOD_NS * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_pulse(input int hi, input int lo);
        bus.din = 1'b1;
        repeat (hi) @(negedge clk);
        bus.din  = 1'b0;
        fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        int hi;
        hi = b ? T1H_CYCLES : T0H_CYCLES;
        drive_pulse(hi, BIT_PERIOD_CYCLES - hi);
    endtask

    task automatic drive_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) drive_bit(p[i]);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_idx_q.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_frame(output logic seen, output logic err_at, output logic err_after);
        seen = 1'b0; err_at = 1'b0; err_after = 1'b0;
        for (int n = 0; n < RESET_LOW + 200; n++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                seen   = 1'b1;
                err_at = bus.bit_error;
                @(negedge clk);
                err_after = bus.bit_error;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.din = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (bus.pixel_data !== 24'h0) begin failures++; $display("FAIL reset_data: got %h expected 000000", bus.pixel_data); end
        if (bus.pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.pixel_valid); end
        if (bus.pixel_index !== '0) begin failures++; $display("FAIL reset_index: got %0d expected 0", bus.pixel_index); end
        if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        if (bus.bit_error !== 1'b0) begin failures++; $display("FAIL reset_bit_error: got %b expected 0", bus.bit_error); end
        if (bus.state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
        reset = 1'b0;
        clear_sb();
        repeat (RESET_LOW + 50) @(negedge clk);
        checks++;
        if (fd_cnt !== 0) begin failures++; $display("FAIL idle_no_frame_done: got %0d expected 0", fd_cnt); end
    endtask

    task automatic test_single_pixel();
        logic seen, ea, eb;
        clear_sb();
        exp_q.push_back(24'h00FF00);
        drive_pixel(24'h00FF00);
        checks += 4;
        if (got_q.size() !== 1) begin failures++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
        else begin
            if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_data: got %h expected %h", got_q[0], exp_q[0]); end
            if (got_idx_q[0] !== 8'd0) begin failures++; $display("FAIL single_index: got %0d expected 0", got_idx_q[0]); end
            if (pv_cyc - fall_cyc !== PV_LAT) begin failures++; $display("FAIL single_latency: got %0d expected %0d", pv_cyc - fall_cyc, PV_LAT); end
        end
        wait_frame(seen, ea, eb);
        checks += 4;
        if (eb !== 1'b0 || ea !== 1'b0) begin failures++; $display("FAIL single_bit_error: got %b%b expected 00", ea, eb); end
        if (!seen) begin failures++; $display("FAIL single_frame_done: got none expected 1"); end
        else if (fd_cyc - fall_cyc !== FD_LAT) begin failures++; $display("FAIL single_fd_latency: got %0d expected %0d", fd_cyc - fall_cyc, FD_LAT); end
        if (bus.pixel_index !== '0) begin failures++; $display("FAIL single_index_after_frame: got %0d expected 0", bus.pixel_index); end
    endtask

    task automatic test_back_to_back();
        logic seen, ea, eb;
        logic [23:0] pix [3];
        pix[0] = 24'h123456; pix[1] = 24'hABCDEF; pix[2] = 24'h000001;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pix[i]);
            drive_pixel(pix[i]);
        end
        wait_frame(seen, ea, eb);
        checks++;
        if (!seen) begin failures++; $display("FAIL b2b_frame_done: got none expected 1"); end
        else if (fd_cyc - fall_cyc !== FD_LAT) begin failures++; $display("FAIL b2b_fd_latency: got %0d expected %0d", fd_cyc - fall_cyc, FD_LAT); end
        repeat (100) @(negedge clk);
        checks += 2;
        if (fd_cnt !== 1) begin failures++; $display("FAIL b2b_fd_count: got %0d expected 1", fd_cnt); end
        if (got_q.size() !== 3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks += 2;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            if (got_idx_q[i] !== IDX_W'(i)) begin failures++; $display("FAIL b2b_index%0d: got %0d expected %0d", i, got_idx_q[i], i); end
        end
    endtask

    task automatic test_glitch();
        logic seen, ea, eb;
        clear_sb();
        for (int i = 23; i >= 0; i--) begin
            if (i == 5) drive_pulse(3, BIT_PERIOD_CYCLES - 3);
            else        drive_bit(1'b1);
        end
        checks += 2;
        // The glitch still shifts in as a 0 bit, so 24 bits complete the pixel.
        if (got_q.size() !== 1 || got_q[0] !== 24'hFFFFDF) begin
            failures++; $display("FAIL glitch_data: got %0d pixels first %h expected 1 pixel ffffdf", got_q.size(), got_q.size() ? got_q[0] : 24'h0);
        end
        if (bus.bit_error !== 1'b1) begin failures++; $display("FAIL glitch_bit_error: got %b expected 1", bus.bit_error); end
        wait_frame(seen, ea, eb);
        checks += 2;
        if (!seen || ea !== 1'b1) begin failures++; $display("FAIL glitch_err_at_fd: got seen=%b err=%b expected 1 1", seen, ea); end
        if (eb !== 1'b0) begin failures++; $display("FAIL glitch_err_cleared: got %b expected 0", eb); end
    endtask

    task automatic test_partial();
        logic seen, ea, eb;
        clear_sb();
        for (int i = 0; i < 10; i++) drive_bit(i[0]);
        wait_frame(seen, ea, eb);
        repeat (5) @(negedge clk);
        checks += 5;
        if (!seen) begin failures++; $display("FAIL partial_frame_done: got none expected 1"); end
        if (got_q.size() !== 0) begin failures++; $display("FAIL partial_no_valid: got %0d expected 0", got_q.size()); end
        if (ea !== 1'b1 || eb !== 1'b1) begin failures++; $display("FAIL partial_err_at_fd: got %b%b expected 11", ea, eb); end
        if (bus.bit_error !== 1'b1) begin failures++; $display("FAIL partial_err_sticky: got %b expected 1", bus.bit_error); end
        if (bus.pixel_index !== '0) begin failures++; $display("FAIL partial_index: got %0d expected 0", bus.pixel_index); end
    endtask

    task automatic test_reset_mid_pixel();
        logic seen, ea, eb;
        clear_sb();
        for (int i = 0; i < 12; i++) drive_bit(1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 2;
        if (bus.bit_error !== 1'b0) begin failures++; $display("FAIL midrst_err_cleared: got %b expected 0", bus.bit_error); end
        if (bus.state !== ST_IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected %0d", bus.state, ST_IDLE); end
        repeat (10) @(negedge clk);
        drive_pixel(24'hA5A5A5);
        wait_frame(seen, ea, eb);
        checks += 4;
        if (got_q.size() !== 1 || got_q[0] !== 24'hA5A5A5) begin
            failures++; $display("FAIL midrst_data: got %0d pixels first %h expected 1 pixel a5a5a5", got_q.size(), got_q.size() ? got_q[0] : 24'h0);
        end
        if (got_idx_q.size() > 0 && got_idx_q[0] !== '0) begin failures++; $display("FAIL midrst_index: got %0d expected 0", got_idx_q[0]); end
        if (fd_cnt !== 1) begin failures++; $display("FAIL midrst_fd_count: got %0d expected 1", fd_cnt); end
        if (ea !== 1'b0) begin failures++; $display("FAIL midrst_bit_error: got %b expected 0", ea); end
    endtask

    task automatic test_high_through_reset();
        logic seen, ea, eb;
        clear_sb();
        bus.din = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        bus.din = 1'b0;
        repeat (30) @(negedge clk);
        drive_pixel(24'h0F0F0F);
        wait_frame(seen, ea, eb);
        checks += 3;
        if (got_q.size() !== 1 || got_q[0] !== 24'h0F0F0F) begin
            failures++; $display("FAIL hold_high_data: got %0d pixels first %h expected 1 pixel 0f0f0f", got_q.size(), got_q.size() ? got_q[0] : 24'h0);
        end
        if (!seen) begin failures++; $display("FAIL hold_high_frame_done: got none expected 1"); end
        if (ea !== 1'b0) begin failures++; $display("FAIL hold_high_bit_error: got %b expected 0", ea); end
    endtask

    task automatic test_loopback();
        logic seen, ea, eb;
        logic [5:0] pat;
        pat = 6'b010110;
        clear_sb();
        // Encoder model: T1H/T0H high time inside a BIT_PERIOD_CYCLES slot.
        for (int i = 5; i >= 0; i--) drive_bit(pat[i]);
        for (int i = 0; i < 18; i++) drive_bit(1'b0);
        wait_frame(seen, ea, eb);
        checks += 2;
        if (got_q.size() !== 1) begin failures++; $display("FAIL loopback_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0][23:18] !== pat) begin failures++; $display("FAIL loopback_bits: got %b expected %b", got_q[0][23:18], pat); end
        if (ea !== 1'b0) begin failures++; $display("FAIL loopback_bit_error: got %b expected 0", ea); end
    endtask

    initial begin
        bus.din = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_glitch();
        test_partial();
        test_reset_mid_pixel();
        test_high_through_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
